// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Contents: default operand width and controller state encoding.
// Encoding 2'd3 is unused and is decoded as IDLE by the controller.
package serial_add_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_bit_cell.sv
// One-bit full-add cell for the serial adder, purely combinational.
// Built from two half adders plus an OR of their carries.
// Ports: a, b, cin (inputs); s, cout (outputs).

// Half adder building block.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  halfadder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  halfadder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: a single shared full-add cell and a carry
// flop add two WIDTH-bit operands LSB first over WIDTH clock cycles.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start_i          request, accepted when ready_o=1
//   a_i, b_i         operands, sampled on the accept edge only
//   sub_i            subtract select (only with SERIAL_ADD_SUB_EN defined)
//   ready_o          high in IDLE
//   busy_o           high in RUN
//   done_o           one-cycle pulse when sum_o/cout_o are updated
//   sum_o, cout_o    registered result, held until the next completion
// Optional feature macro: SERIAL_ADD_SUB_EN (adds sub_i; A-B via ~B + 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub_i,
`endif
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cell_s;
  logic             cell_co;
  logic [WIDTH-1:0] b_load;
  logic             carry_init;

  // Operand B and initial carry as loaded on accept.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = sub_i ? ~b_i : b_i;
  assign carry_init = sub_i;
`else
  assign b_load     = b_i;
  assign carry_init = 1'b0;
`endif

  // Shared add cell works on the current LSBs and the carry flop.
  serial_bit_cell u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_co)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      ST_RUN: begin
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        r_sr_d  = {cell_s, r_sr_q[WIDTH-1:1]};
        carry_d = cell_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          sum_d   = {cell_s, r_sr_q[WIDTH-1:1]};
          cout_d  = cell_co;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        // IDLE, and the unused encoding which behaves as IDLE.
        if (start_i) begin
          state_d = ST_RUN;
          a_sr_d  = a_i;
          b_sr_d  = b_load;
          carry_d = carry_init;
          cnt_d   = '0;
        end
      end
    endcase

    // Status flags track the state being entered so they are registered.
    ready_d = (state_d != ST_RUN) && (state_d != ST_DONE);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit instance covering add,
// held-start throughput, mid-run reset and (with SERIAL_ADD_SUB_EN)
// subtraction, plus a 2-bit instance for the minimum width.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start_i;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       ready_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] sum_o;
  logic       cout_o;

  logic       start2_i;
  logic [1:0] a2_i;
  logic [1:0] b2_i;
  logic       ready2_o;
  logic       busy2_o;
  logic       done2_o;
  logic [1:0] sum2_o;
  logic       cout2_o;

`ifdef SERIAL_ADD_SUB_EN
  logic       sub_i;
`endif

  int checks;
  int errors;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
`ifdef SERIAL_ADD_SUB_EN
    .sub_i   (sub_i),
`endif
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
    .cout_o  (cout_o)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start2_i),
    .a_i     (a2_i),
    .b_i     (b2_i),
`ifdef SERIAL_ADD_SUB_EN
    .sub_i   (1'b0),
`endif
    .ready_o (ready2_o),
    .busy_o  (busy2_o),
    .done_o  (done2_o),
    .sum_o   (sum2_o),
    .cout_o  (cout2_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling happens 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the 8-bit instance with mid-run noise on inputs.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_sum, input logic exp_cout,
                       input logic [7:0] prev_sum);
    check("pre_ready", 32'(ready_o), 32'd1);
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    a_i     = 8'($urandom);
    b_i     = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      check("run_busy", 32'(busy_o), 32'd1);
      check("run_done", 32'(done_o), 32'd0);
      check("run_hold", 32'(sum_o), 32'(prev_sum));
      if (i == 2) begin
        start_i = 1'b1;
        a_i     = 8'($urandom);
        b_i     = 8'($urandom);
      end
      if (i == 3) start_i = 1'b0;
      tick();
    end
    check("done_hi", 32'(done_o), 32'd1);
    check("done_busy", 32'(busy_o), 32'd0);
    check("sum", 32'(sum_o), 32'(exp_sum));
    check("cout", 32'(cout_o), 32'(exp_cout));
    tick();
    check("done_lo", 32'(done_o), 32'd0);
    check("ready_back", 32'(ready_o), 32'd1);
    check("sum_kept", 32'(sum_o), 32'(exp_sum));
  endtask

  logic [7:0] h_a   [0:3];
  logic [7:0] h_b   [0:3];
  logic [7:0] h_sum [0:2];
  logic       h_co  [0:2];

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b1;
    start_i  = 1'b0;
    a_i      = '0;
    b_i      = '0;
    start2_i = 1'b0;
    a2_i     = '0;
    b2_i     = '0;
`ifdef SERIAL_ADD_SUB_EN
    sub_i    = 1'b0;
`endif
    #3 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_sum", 32'(sum_o), 32'd0);
    check("rst_cout", 32'(cout_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic additions, result held through each following run.
    do_op(8'd3,   8'd5,   8'd8,   1'b0, 8'd0);
    do_op(8'hFF,  8'h01,  8'h00,  1'b1, 8'd8);
    do_op(8'hAA,  8'h55,  8'hFF,  1'b0, 8'h00);

    // start_i held high: accepts every 10 cycles, noise on operands mid-run.
    h_a[0] = 8'd10;  h_b[0] = 8'd20;  h_sum[0] = 8'd30;  h_co[0] = 1'b0;
    h_a[1] = 8'd200; h_b[1] = 8'd100; h_sum[1] = 8'd44;  h_co[1] = 1'b1;
    h_a[2] = 8'd255; h_b[2] = 8'd255; h_sum[2] = 8'd254; h_co[2] = 1'b1;
    h_a[3] = 8'd0;   h_b[3] = 8'd0;
    a_i     = h_a[0];
    b_i     = h_b[0];
    start_i = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if ((k % 10) == 0) begin
        a_i = 8'($urandom);
        b_i = 8'($urandom);
      end
      if ((k % 10) == 8) begin
        check("held_done", 32'(done_o), 32'd1);
        check("held_sum", 32'(sum_o), 32'(h_sum[k / 10]));
        check("held_cout", 32'(cout_o), 32'(h_co[k / 10]));
      end else begin
        check("held_nodone", 32'(done_o), 32'd0);
      end
      check("held_ready", 32'(ready_o), 32'((k % 10) == 9));
      if ((k % 10) == 9) begin
        a_i = h_a[k / 10 + 1];
        b_i = h_b[k / 10 + 1];
      end
    end
    start_i = 1'b0;
    tick();
    tick();
    check("held_idle", 32'(ready_o), 32'd1);

    // Asynchronous reset in the middle of a run.
    a_i     = 8'd100;
    b_i     = 8'd27;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(ready_o), 32'd1);
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_sum", 32'(sum_o), 32'd0);
    check("arst_cout", 32'(cout_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("arst_nodone", 32'(done_o), 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_nodone", 32'(done_o), 32'd0);
    end
    do_op(8'd1, 8'd1, 8'd2, 1'b0, 8'd0);

`ifdef SERIAL_ADD_SUB_EN
    sub_i = 1'b1;
    do_op(8'd5, 8'd3, 8'd2,   1'b1, 8'd2);
    do_op(8'd3, 8'd5, 8'd254, 1'b0, 8'd2);
    sub_i = 1'b0;
    do_op(8'd3, 8'd5, 8'd8,   1'b0, 8'd254);
`endif

    // Minimum-width instance.
    a2_i     = 2'd3;
    b2_i     = 2'd3;
    start2_i = 1'b1;
    tick();
    start2_i = 1'b0;
    check("w2_busy", 32'(busy2_o), 32'd1);
    tick();
    check("w2_nodone", 32'(done2_o), 32'd0);
    tick();
    check("w2_done", 32'(done2_o), 32'd1);
    check("w2_sum", 32'(sum2_o), 32'd2);
    check("w2_cout", 32'(cout2_o), 32'd1);
    tick();
    check("w2_done_lo", 32'(done2_o), 32'd0);
    check("w2_ready", 32'(ready2_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
